// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Definitions shared by the dcache memory interface and the backing line
// memory: line width, byte-address width, byte-offset bits inside a line and
// the responder state encoding.
// ---------------------------------------------------------------------------
package mem_if_pkg;

    localparam int LINE_W           = 256;
    localparam int ADDR_W           = 32;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a request
        ST_BUSY = 2'd1,   // latency countdown
        ST_DONE = 2'd2    // ack cycle
    } mem_state_e;

endpackage : mem_if_pkg

// File: rtl/mem_line_array.sv
// ---------------------------------------------------------------------------
// mem_line_array
// 2^LINE_ADDR_BITS x LINE_W line storage.
//   clk_i  : clock
//   we     : write enable, line written at the rising edge
//   idx    : line index shared by the write and read ports
//   wdata  : line to write
//   rdata  : combinational read of the indexed line
// ---------------------------------------------------------------------------
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int LINE_ADDR_BITS = 9
) (
    input  logic                      clk_i,
    input  logic                      we,
    input  logic [LINE_ADDR_BITS-1:0] idx,
    input  logic [LINE_W-1:0]         wdata,
    output logic [LINE_W-1:0]         rdata
);

    localparam int DEPTH = 1 << LINE_ADDR_BITS;

    logic [LINE_W-1:0] lines [DEPTH];

    // NOTE: the storage has no reset. Clearing a RAM would defeat inference
    // and contents must survive a controller reset anyway.
    always_ff @(posedge clk_i) begin
        if (we) begin
            lines[idx] <= wdata;
        end
    end

    assign rdata = lines[idx];

endmodule : mem_line_array

// File: rtl/data_memory_line.sv
// ---------------------------------------------------------------------------
// data_memory_line
// Line-granular backing memory answering the dcache's refill reads and dirty
// write-backs. A request is sampled in IDLE. After a fixed latency, a
// one-cycle ack is returned. The ack rises LATENCY edges after the edge at
// which the requester raised mem_enable_i.
//   clk_i        : clock
//   rst_i        : asynchronous active-low reset
//   mem_enable_i : request valid (level), sampled only in IDLE
//   mem_write_i  : 1 = write line, 0 = read line
//   mem_addr_i   : byte address; [4:0] ignored, upper bits alias
//   mem_data_i   : line to write
//   mem_ack_o    : one-cycle completion pulse
//   mem_data_o   : read line, valid with the ack of a read, held otherwise
// ---------------------------------------------------------------------------
module data_memory_line
    import mem_if_pkg::*;
#(
    parameter int LATENCY        = 10,
    parameter int LINE_ADDR_BITS = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o
);

    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a single cycle of latency the BUSY phase vanishes entirely.
    localparam bit               DIRECT   = (LATENCY == 1);

    mem_state_e                state;
    logic [CNT_W-1:0]          cnt;
    logic [LINE_ADDR_BITS-1:0] hold_idx;
    logic                      hold_write;
    logic [LINE_W-1:0]         hold_data;

    logic [LINE_ADDR_BITS-1:0] req_idx;
    logic                      enter_done;
    logic                      enter_write;
    logic                      arr_we;
    logic [LINE_ADDR_BITS-1:0] arr_idx;
    logic [LINE_W-1:0]         arr_wdata;
    logic [LINE_W-1:0]         arr_rdata;
    logic                      unused_addr_bits;

    assign req_idx          = mem_addr_i[LINE_OFFSET_BITS +: LINE_ADDR_BITS];
    assign unused_addr_bits = ^{mem_addr_i[ADDR_W-1:LINE_OFFSET_BITS+LINE_ADDR_BITS],
                                mem_addr_i[LINE_OFFSET_BITS-1:0]};

    // Array access happens on the edge that enters DONE. On the direct path
    // the holding regs are being loaded on that same edge, so the live
    // request is used instead.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        enter_done  = 1'b0;
        enter_write = hold_write;
        arr_idx     = hold_idx;
        arr_wdata   = hold_data;
        case (state)
            ST_IDLE: begin
                if (DIRECT && mem_enable_i) begin
                    enter_done  = 1'b1;
                    enter_write = mem_write_i;
                    arr_idx     = req_idx;
                    arr_wdata   = mem_data_i;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_ONE) begin
                    enter_done = 1'b1;
                end
            end
            default: ;
        endcase
        // Writes are gated by reset. A held reset cannot commit a line.
        arr_we = enter_done & enter_write & rst_i;
    end

    mem_line_array #(
        .LINE_ADDR_BITS(LINE_ADDR_BITS)
    ) u_array (
        .clk_i (clk_i),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_idx   <= '0;
            hold_write <= 1'b0;
            hold_data  <= '0;
            mem_ack_o  <= 1'b0;
            mem_data_o <= '0;
        end else begin
            mem_ack_o <= enter_done;
            // Read data is captured only for reads. Write acks leave it untouched.
            if (enter_done && !enter_write) begin
                mem_data_o <= arr_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (mem_enable_i) begin
                        hold_idx   <= req_idx;
                        hold_write <= mem_write_i;
                        hold_data  <= mem_data_i;
                        cnt        <= CNT_LOAD;
                        state      <= DIRECT ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_DONE;
                    end
                end
                // The ack cycle never samples a request.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : data_memory_line
